// File: rtl/rc4_ksa_fsm.sv
// RC4 key-scheduling pass: shuffles the identity S table in place through a
// single-port synchronous RAM, seven cycles per index, finish pulse at the end.
module rc4_ksa_fsm #(
  parameter int unsigned KEY_LENGTH = 3,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [8*KEY_LENGTH-1:0] key,
  output logic                    finish,
  output logic                    busy,
  output logic [ADDR_WIDTH-1:0]   mem_address,
  output logic [DATA_WIDTH-1:0]   mem_data,
  output logic                    mem_wren,
  input  logic [DATA_WIDTH-1:0]   mem_q
);

  localparam int unsigned KEY_W  = 8 * KEY_LENGTH;
  localparam int unsigned K_W    = (KEY_LENGTH > 1) ? $clog2(KEY_LENGTH) : 1;
  localparam int unsigned LAST_I = (1 << ADDR_WIDTH) - 1;

  typedef enum logic [3:0] {
    IDLE,
    RD_I,
    LAT_I,
    RD_J,
    LAT_J,
    WR_I,
    WR_J,
    NEXT,
    DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   i_q, i_d;
  logic [ADDR_WIDTH-1:0]   j_q, j_d;
  logic [K_W-1:0]          k_q, k_d;
  logic [DATA_WIDTH-1:0]   si_q, si_d;
  logic [DATA_WIDTH-1:0]   sj_q, sj_d;
  logic [KEY_W-1:0]        key_q, key_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    wren_q, wren_d;
  logic                    finish_q, finish_d;
  logic                    busy_q, busy_d;
  logic [7:0]              key_byte_c;

  // Key byte k, byte 0 being the most significant byte of the latched key.
  always_comb begin
    key_byte_c = '0;
    for (int b = 0; b < int'(KEY_LENGTH); b++) begin
      if (k_q == K_W'(b)) key_byte_c = key_q[KEY_W-1-8*b -: 8];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      si_q     <= '0;
      sj_q     <= '0;
      key_q    <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      wren_q   <= 1'b0;
      finish_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      j_q      <= j_d;
      k_q      <= k_d;
      si_q     <= si_d;
      sj_q     <= sj_d;
      key_q    <= key_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      wren_q   <= wren_d;
      finish_q <= finish_d;
      busy_q   <= busy_d;
    end
  end

  // Next state, datapath updates, and memory outputs decoded from the state being entered.
  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    j_d      = j_q;
    k_d      = k_q;
    si_d     = si_q;
    sj_d     = sj_q;
    key_d    = key_q;
    addr_d   = '0;
    data_d   = '0;
    wren_d   = 1'b0;
    finish_d = 1'b0;
    busy_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          key_d   = key;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          state_d = RD_I;
        end
      end
      RD_I:  state_d = LAT_I;
      LAT_I: begin
        si_d    = mem_q;
        j_d     = j_q + ADDR_WIDTH'(mem_q) + ADDR_WIDTH'(key_byte_c);
        state_d = RD_J;
      end
      RD_J:  state_d = LAT_J;
      LAT_J: begin
        sj_d    = mem_q;
        state_d = WR_I;
      end
      WR_I:  state_d = WR_J;
      WR_J:  state_d = NEXT;
      NEXT: begin
        if (i_q == ADDR_WIDTH'(LAST_I)) begin
          state_d = DONE;
        end else begin
          i_d     = i_q + ADDR_WIDTH'(1);
          k_d     = (k_q == K_W'(KEY_LENGTH - 1)) ? '0 : k_q + K_W'(1);
          state_d = RD_I;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    unique case (state_d)
      RD_I: addr_d = i_d;
      RD_J: addr_d = j_d;
      WR_I: begin
        addr_d = i_d;
        data_d = sj_d;
        wren_d = 1'b1;
      end
      WR_J: begin
        addr_d = j_d;
        data_d = si_d;
        wren_d = 1'b1;
      end
      DONE:    finish_d = 1'b1;
      default: ;
    endcase

    busy_d = (state_d != IDLE);
  end

  assign finish      = finish_q;
  assign busy        = busy_q;
  assign mem_address = addr_q;
  assign mem_data    = data_q;
  assign mem_wren    = wren_q;

endmodule

// File: tb/tb_rc4_ksa_fsm.sv
// Bench for rc4_ksa_fsm: behavioural S RAM, software KSA reference, directed
// write-trace vectors plus reset, key-latch and held-start sequences.
module tb_rc4_ksa_fsm;

  logic        clock;
  logic        reset;
  logic        start;
  logic [23:0] key;
  logic        finish;
  logic        busy;
  logic [7:0]  mem_address;
  logic [7:0]  mem_data;
  logic        mem_wren;
  logic [7:0]  mem_q;

  rc4_ksa_fsm #(.KEY_LENGTH(3), .ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .key         (key),
    .finish      (finish),
    .busy        (busy),
    .mem_address (mem_address),
    .mem_data    (mem_data),
    .mem_wren    (mem_wren),
    .mem_q       (mem_q)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [7:0] mem [256];
  logic       init_mem;

  // Single-port synchronous RAM with registered read data.
  always @(posedge clock) begin
    if (init_mem) begin
      for (int a = 0; a < 256; a++) mem[a] <= 8'(a);
    end else if (mem_wren) begin
      mem[mem_address] <= mem_data;
    end
    mem_q <= mem[mem_address];
  end

  int checks;
  int failures;

  logic [7:0]  exp_s [256];
  logic [15:0] wr_log [$];
  int          fin_cyc [$];
  int          busy_low [$];
  int          busy_cnt;
  int          busy_first;
  int          wr_cnt;

  typedef struct {
    logic [23:0] key;
    logic [15:0] wr [6];
  } vec_t;

  vec_t vecs [3];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic load_identity();
    init_mem = 1'b1;
    next_cycle();
    init_mem = 1'b0;
    for (int a = 0; a < 256; a++) exp_s[a] = 8'(a);
  endtask

  // Reference KSA applied to exp_s in place.
  task automatic model(input logic [23:0] k);
    logic [7:0] j;
    logic [7:0] t;
    logic [7:0] kb;
    j = 8'd0;
    for (int i = 0; i < 256; i++) begin
      kb = 8'(k >> (16 - 8 * (i % 3)));
      j = j + exp_s[i] + kb;
      t = exp_s[i];
      exp_s[i] = exp_s[j];
      exp_s[j] = t;
    end
  endtask

  task automatic clear_stats();
    wr_log.delete();
    fin_cyc.delete();
    busy_low.delete();
    busy_cnt   = 0;
    busy_first = -1;
    wr_cnt     = 0;
  endtask

  task automatic check_mem(input string nm);
    int bad;
    bad = 0;
    for (int a = 0; a < 256; a++) if (mem[a] !== exp_s[a]) bad++;
    chk(nm, 64'(bad), 64'd0);
  endtask

  // mode 0 plain pass, 1 key change + start while busy, 2 reset at 500 and
  // restart at 510, 3 start held high. Cycle 0 is the start-accept cycle.
  task automatic run(input logic [23:0] k, input int ncyc, input int mode);
    clear_stats();
    key   = k;
    start = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      next_cycle();
      if (mode != 3 && c == 1) start = 1'b0;
      if (finish) fin_cyc.push_back(c);
      if (busy) begin
        busy_cnt++;
        if (busy_first < 0) busy_first = c;
      end else begin
        busy_low.push_back(c);
      end
      if (mem_wren) begin
        wr_cnt++;
        wr_log.push_back({mem_address, mem_data});
      end
      if (mode == 1) begin
        if (c == 10) key = 24'hFFFFFF;
        if (c == 100) start = 1'b1;
        if (c == 101) start = 1'b0;
      end
      if (mode == 2) begin
        if (c == 500) reset = 1'b1;
        if (c == 501) begin
          chk("rst_busy", 64'(busy), 64'd0);
          chk("rst_wren", 64'(mem_wren), 64'd0);
          chk("rst_finish", 64'(finish), 64'd0);
          reset = 1'b0;
        end
        if (c == 510) begin
          for (int a = 0; a < 256; a++) exp_s[a] = mem[a];
          model(k);
          clear_stats();
          start = 1'b1;
        end
        if (c == 511) begin
          chk("restart_addr", 64'(mem_address), 64'd0);
          chk("restart_wren", 64'(mem_wren), 64'd0);
          start = 1'b0;
        end
      end
    end
  endtask

  task automatic check_trace(input int v);
    logic [15:0] act;
    for (int w = 0; w < 6; w++) begin
      act = (w < wr_log.size()) ? wr_log[w] : 16'hxxxx;
      chk($sformatf("v%0d_wr%0d", v, w), 64'(act), 64'(vecs[v].wr[w]));
    end
  endtask

  task automatic check_timing(input string nm, input int fin_exp);
    chk({nm, "_fin_cnt"}, 64'(fin_cyc.size()), 64'd1);
    chk({nm, "_fin_cyc"}, 64'((fin_cyc.size() > 0) ? fin_cyc[0] : -1), 64'(fin_exp));
    chk({nm, "_wr_cnt"}, 64'(wr_cnt), 64'd512);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    start    = 1'b0;
    key      = '0;
    init_mem = 1'b0;

    vecs[0].key = 24'h010203;
    vecs[0].wr  = '{16'h0001, 16'h0100, 16'h0103, 16'h0300, 16'h0208, 16'h0802};
    vecs[1].key = 24'h000000;
    vecs[1].wr  = '{16'h0000, 16'h0000, 16'h0101, 16'h0101, 16'h0203, 16'h0302};
    vecs[2].key = 24'hFFFFFF;
    vecs[2].wr  = '{16'h00FF, 16'hFF00, 16'h0100, 16'hFF01, 16'h02FF, 16'h0002};

    next_cycle();
    next_cycle();
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_finish", 64'(finish), 64'd0);
    chk("reset_wren", 64'(mem_wren), 64'd0);
    chk("reset_addr", 64'(mem_address), 64'd0);
    chk("reset_data", 64'(mem_data), 64'd0);
    reset = 1'b0;
    next_cycle();

    for (int v = 0; v < 3; v++) begin
      load_identity();
      model(vecs[v].key);
      run(vecs[v].key, 1800, 0);
      check_trace(v);
      check_timing($sformatf("v%0d", v), 1793);
      chk($sformatf("v%0d_busy_cnt", v), 64'(busy_cnt), 64'd1793);
      chk($sformatf("v%0d_busy_first", v), 64'(busy_first), 64'd1);
      check_mem($sformatf("v%0d_mem", v));
    end

    load_identity();
    model(24'h010203);
    run(24'h010203, 1800, 1);
    check_timing("keylatch", 1793);
    check_mem("keylatch_mem");

    load_identity();
    run(24'h0A0B0C, 2310, 2);
    check_timing("rstpass", 2303);
    check_mem("rstpass_mem");

    load_identity();
    run(24'h000000, 3600, 3);
    chk("hold_fin_cnt", 64'(fin_cyc.size()), 64'd2);
    chk("hold_fin0", 64'((fin_cyc.size() > 0) ? fin_cyc[0] : -1), 64'd1793);
    chk("hold_fin1", 64'((fin_cyc.size() > 1) ? fin_cyc[1] : -1), 64'd3587);
    chk("hold_idle_cnt", 64'(busy_low.size()), 64'd2);
    chk("hold_idle0", 64'((busy_low.size() > 0) ? busy_low[0] : -1), 64'd1794);
    chk("hold_idle1", 64'((busy_low.size() > 1) ? busy_low[1] : -1), 64'd3588);
    start = 1'b0;
    reset = 1'b1;
    next_cycle();
    chk("abort_busy", 64'(busy), 64'd0);

    start = 1'b1;
    next_cycle();
    chk("rst_start_busy", 64'(busy), 64'd0);
    reset = 1'b0;
    start = 1'b0;
    next_cycle();
    chk("rst_start_idle", 64'(busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
